// File: rtl/caster_pkg.sv
// Shared types and default timing for the caster EPD scan controller.
// Holds the FSM state enum, the counter width and the panel pin bundle.
package caster_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACT    = 200;
    localparam int DEF_LE_WIDTH = 4;
    localparam int DEF_H_BLANK  = 20;
    localparam int DEF_V_ACT    = 1200;
    localparam int DEF_V_BLANK  = 100;
    localparam int DEF_SP_WIDTH = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSTART,
        ST_HDATA,
        ST_HLATCH,
        ST_HGATE,
        ST_VBLANK,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic gdoe;
        logic gdclk;
        logic gdsp;
        logic sdclk;
        logic sdle;
        logic sdoe;
        logic sdce0;
    } pins_t;

    localparam pins_t PINS_IDLE = '{gdoe: 1'b0, gdclk: 1'b0, gdsp: 1'b0, sdclk: 1'b0,
                                    sdle: 1'b0, sdoe: 1'b0, sdce0: 1'b1};

    // Load value for a down-counter that must run for n cycles and stop at zero.
    function automatic cnt_t tc(input int n);
        return cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/epd_scan_ctrl_if.sv
// Pixel handshake and panel pin bundle between the scan controller and its neighbours.
interface epd_scan_ctrl_if;

    logic px_req;
    logic px_valid;
    logic epd_gdoe;
    logic epd_gdclk;
    logic epd_gdsp;
    logic epd_sdclk;
    logic epd_sdle;
    logic epd_sdoe;
    logic epd_sdce0;

    modport master (
        output px_req, epd_gdoe, epd_gdclk, epd_gdsp, epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0,
        input  px_valid
    );

    modport slave (
        input  px_req, epd_gdoe, epd_gdclk, epd_gdsp, epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0,
        output px_valid
    );

endinterface

// File: rtl/caster_dcnt.sv
// Loadable down-counter that saturates at zero; zero flags the terminal cycle.
module caster_dcnt
    import caster_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    input  cnt_t load_val,
    output logic zero
);

    cnt_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/epd_scan_ctrl.sv
// EPD frame scan scheduler: sequences gate/source driver pins for one frame per request
// and pulls source words over a ready/valid handshake; aborts when panel power drops.
module epd_scan_ctrl
    import caster_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int LE_WIDTH = DEF_LE_WIDTH,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int SP_WIDTH = DEF_SP_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pok,
    input  logic frame_req,
    output logic frame_busy,
    output logic frame_done,
    output logic frame_abort,
    output logic underrun,
    epd_scan_ctrl_if.master bus
);

    state_e state_q, state_d;
    logic   phase_q, phase_d;       // sdclk phase inside HDATA: 0 = low, 1 = high
    logic   underrun_q, underrun_d;
    logic   abort_d;

    logic   cyc_load, cyc_dec, cyc_zero;
    cnt_t   cyc_val;
    logic   word_load, word_dec, word_zero;
    logic   line_load, line_dec, line_zero;

    pins_t  pins_q, pins_d;
    logic   px_req_q, px_req_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   abort_q;

    caster_dcnt u_cyc (.clk(clk), .rst_n(rst_n), .load(cyc_load), .dec(cyc_dec),
                       .load_val(cyc_val), .zero(cyc_zero));
    caster_dcnt u_word (.clk(clk), .rst_n(rst_n), .load(word_load), .dec(word_dec),
                        .load_val(tc(H_ACT)), .zero(word_zero));
    caster_dcnt u_line (.clk(clk), .rst_n(rst_n), .load(line_load), .dec(line_dec),
                        .load_val(tc(V_ACT)), .zero(line_zero));

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        underrun_d = underrun_q;
        abort_d    = 1'b0;
        cyc_load   = 1'b0;
        cyc_dec    = 1'b0;
        cyc_val    = '0;
        word_load  = 1'b0;
        word_dec   = 1'b0;
        line_load  = 1'b0;
        line_dec   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_req && pok) begin
                    state_d    = ST_VSTART;
                    cyc_load   = 1'b1;
                    cyc_val    = tc(1 + SP_WIDTH);
                    underrun_d = 1'b0;
                end
            end
            ST_VSTART: begin
                if (cyc_zero) begin
                    state_d   = ST_HDATA;
                    phase_d   = 1'b0;
                    word_load = 1'b1;
                    line_load = 1'b1;
                end else begin
                    cyc_dec = 1'b1;
                end
            end
            ST_HDATA: begin
                if (!phase_q) begin
                    // Without a word the low phase repeats and the stall is recorded.
                    if (bus.px_valid) phase_d = 1'b1;
                    else              underrun_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (word_zero) begin
                        state_d  = ST_HLATCH;
                        cyc_load = 1'b1;
                        cyc_val  = tc(LE_WIDTH);
                    end else begin
                        word_dec = 1'b1;
                    end
                end
            end
            ST_HLATCH: begin
                if (cyc_zero) begin
                    state_d  = ST_HGATE;
                    cyc_load = 1'b1;
                    cyc_val  = tc(H_BLANK);
                end else begin
                    cyc_dec = 1'b1;
                end
            end
            ST_HGATE: begin
                if (!cyc_zero) begin
                    cyc_dec = 1'b1;
                end else if (line_zero) begin
                    state_d  = ST_VBLANK;
                    cyc_load = 1'b1;
                    cyc_val  = tc(V_BLANK);
                end else begin
                    state_d   = ST_HDATA;
                    phase_d   = 1'b0;
                    line_dec  = 1'b1;
                    word_load = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (cyc_zero) state_d = ST_DONE;
                else          cyc_dec = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Power loss overrides every transition, DONE included.
        if ((state_q != ST_IDLE) && !pok) begin
            state_d    = ST_IDLE;
            phase_d    = 1'b0;
            underrun_d = underrun_q;
            abort_d    = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        pins_d   = PINS_IDLE;
        px_req_d = 1'b0;
        unique case (state_d)
            ST_VSTART: begin
                pins_d.gdsp  = 1'b1;
                pins_d.gdoe  = 1'b1;
                pins_d.sdoe  = 1'b1;
                pins_d.gdclk = (state_q == ST_VSTART);
            end
            ST_HDATA: begin
                pins_d.gdoe  = 1'b1;
                pins_d.sdoe  = 1'b1;
                pins_d.sdce0 = 1'b0;
                pins_d.sdclk = phase_d;
                px_req_d     = !phase_d;
            end
            ST_HLATCH: begin
                pins_d.gdoe = 1'b1;
                pins_d.sdoe = 1'b1;
                pins_d.sdle = 1'b1;
            end
            ST_HGATE: begin
                pins_d.gdoe  = 1'b1;
                pins_d.sdoe  = 1'b1;
                pins_d.gdclk = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            underrun_q <= 1'b0;
            pins_q     <= PINS_IDLE;
            px_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
            pins_q     <= pins_d;
            px_req_q   <= px_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.px_req    = px_req_q;
    assign bus.epd_gdoe  = pins_q.gdoe;
    assign bus.epd_gdclk = pins_q.gdclk;
    assign bus.epd_gdsp  = pins_q.gdsp;
    assign bus.epd_sdclk = pins_q.sdclk;
    assign bus.epd_sdle  = pins_q.sdle;
    assign bus.epd_sdoe  = pins_q.sdoe;
    assign bus.epd_sdce0 = pins_q.sdce0;

    assign frame_busy  = busy_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign underrun    = underrun_q;

endmodule
